// File: rtl/two_pulses_gen.sv
// Frame generator: an opening x pulse, N y pulses, then a closing x pulse,
// with G idle cycles between adjacent pulses; supports abort and reject strobes.
module two_pulses_gen #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] ycnt_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             x_o,
    output logic             y_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        IDLE,
        X_OPEN,
        GAP,
        Y_PULSE,
        X_CLOSE,
        DONE
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] y_left;
    logic             more_y;

    assign more_y = (y_left != '0);

    // Frame sequencer; every output is set together with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gap_q   <= '0;
            gap_cnt <= '0;
            y_left  <= '0;
            x_o     <= 1'b0;
            y_o     <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            x_o    <= 1'b0;
            y_o    <= 1'b0;
            done_o <= 1'b0;
            err_o  <= start_i && busy_o;
            if (abort_i && (state != IDLE)) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !abort_i) begin
                            gap_q  <= gap_i;
                            y_left <= ycnt_i;
                            state  <= X_OPEN;
                            x_o    <= 1'b1;
                            busy_o <= 1'b1;
                        end
                    end
                    X_OPEN, Y_PULSE: begin
                        if (gap_q != '0) begin
                            state   <= GAP;
                            gap_cnt <= gap_q - GAP_W'(1);
                        end else if (more_y) begin
                            state  <= Y_PULSE;
                            y_o    <= 1'b1;
                            y_left <= y_left - CNT_W'(1);
                        end else begin
                            state <= X_CLOSE;
                            x_o   <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else if (more_y) begin
                            state  <= Y_PULSE;
                            y_o    <= 1'b1;
                            y_left <= y_left - CNT_W'(1);
                        end else begin
                            state <= X_CLOSE;
                            x_o   <= 1'b1;
                        end
                    end
                    X_CLOSE: begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_two_pulses_gen.sv
// Bench for two_pulses_gen: directed frames pinned by literal waveforms, then
// random traffic checked every cycle against an arithmetic frame-schedule model.
module tb_two_pulses_gen;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 4;

    logic             clk;
    logic             reset;
    logic             start_i;
    logic [CNT_W-1:0] ycnt_i;
    logic [GAP_W-1:0] gap_i;
    logic             abort_i;
    logic             x_o, y_o, busy_o, done_o, err_o;

    two_pulses_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_i),
        .ycnt_i  (ycnt_i),
        .gap_i   (gap_i),
        .abort_i (abort_i),
        .x_o     (x_o),
        .y_o     (y_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: the active frame is described only by its start cycle, N and G.
    bit m_active  = 1'b0;
    int m_k       = 0;
    int m_n       = 0;
    int m_g       = 0;
    int m_dn      = 0;
    bit m_err     = 1'b0;

    int base = 0;
    logic [31:0] hx, hy, hd, hb, he;

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0b expected=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return m_active && (c >= m_k + 1) && (c <= m_dn);
    endfunction

    task automatic check_outputs();
        int  d, g1;
        bit  b, ex, ey, ed;
        b  = m_busy(cyc);
        d  = cyc - m_k - 1;
        g1 = m_g + 1;
        ex = b && ((d == 0) || (d == (m_n + 1) * g1));
        ey = b && (d % g1 == 0) && (d / g1 >= 1) && (d / g1 <= m_n);
        ed = b && (cyc == m_dn);
        cmp("x_o", x_o, ex);
        cmp("y_o", y_o, ey);
        cmp("busy_o", busy_o, b);
        cmp("done_o", done_o, ed);
        cmp("err_o", err_o, m_err);
        if (cyc - base >= 0 && cyc - base < 32) begin
            hx[cyc-base] = x_o;
            hy[cyc-base] = y_o;
            hd[cyc-base] = done_o;
            hb[cyc-base] = busy_o;
            he[cyc-base] = err_o;
        end
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic drive(input bit s, input bit a, input int n, input int g);
        bit b;
        start_i = s;
        abort_i = a;
        ycnt_i  = CNT_W'(n);
        gap_i   = GAP_W'(g);
        b       = m_busy(cyc);
        m_err   = s && b;
        if (b && a) begin
            m_active = 1'b0;
        end else if (!b && s && !a) begin
            m_active = 1'b1;
            m_k      = cyc;
            m_n      = n;
            m_g      = g;
            m_dn     = m_k + 2 + (n + 1) * (g + 1);
        end
    endtask

    task automatic step(input bit s, input bit a, input int n, input int g);
        tick_check();
        drive(s, a, n, g);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic begin_scn();
        base = cyc + 1;
        hx = '0; hy = '0; hd = '0; hb = '0; he = '0;
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        ycnt_i  = '0;
        gap_i   = '0;
        #12;
        cmp("rst_x", x_o, 1'b0);
        cmp("rst_busy", busy_o, 1'b0);
        cmp("rst_err", err_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // N=2 G=0
        begin_scn();
        step(1'b1, 1'b0, 2, 0);
        idle(7);
        cmp32("n2g0_x", hx, 32'h12);
        cmp32("n2g0_y", hy, 32'h0C);
        cmp32("n2g0_done", hd, 32'h20);
        cmp32("n2g0_busy", hb, 32'h3E);
        idle(2);

        // N=3 G=1
        begin_scn();
        step(1'b1, 1'b0, 3, 1);
        idle(11);
        cmp32("n3g1_x", hx, 32'h202);
        cmp32("n3g1_y", hy, 32'hA8);
        cmp32("n3g1_done", hd, 32'h400);
        idle(2);

        // N=0 G=2
        begin_scn();
        step(1'b1, 1'b0, 0, 2);
        idle(6);
        cmp32("n0g2_x", hx, 32'h12);
        cmp32("n0g2_y", hy, 32'h0);
        cmp32("n0g2_done", hd, 32'h20);
        idle(2);

        // Second start mid-frame is rejected
        begin_scn();
        step(1'b1, 1'b0, 2, 0);
        idle(2);
        step(1'b1, 1'b0, 5, 3);
        idle(6);
        cmp32("rej_err", he, 32'h10);
        cmp32("rej_x", hx, 32'h12);
        cmp32("rej_y", hy, 32'h0C);
        cmp32("rej_done", hd, 32'h20);
        idle(2);

        // Abort in cycle 4, restart in cycle 6
        begin_scn();
        step(1'b1, 1'b0, 3, 1);
        idle(3);
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 3, 1);
        step(1'b0, 1'b0, 0, 0);
        cmp32("abort_x", hx, 32'h82);
        cmp32("abort_y", hy, 32'h08);
        cmp32("abort_done", hd, 32'h0);
        cmp32("abort_busy", hb, 32'h9E);
        idle(12);

        // Reset asserted mid-cycle 6 of a frame
        begin_scn();
        step(1'b1, 1'b0, 3, 1);
        idle(6);
        #3;
        reset    = 1'b1;
        m_active = 1'b0;
        m_err    = 1'b0;
        #1;
        cmp("async_x", x_o, 1'b0);
        cmp("async_y", y_o, 1'b0);
        cmp("async_busy", busy_o, 1'b0);
        tick_check();
        tick_check();
        reset = 1'b0;
        drive(1'b1, 1'b0, 3, 1);
        begin_scn();
        base = cyc;
        idle(12);
        cmp32("post_rst_x", hx, 32'h202);
        cmp32("post_rst_y", hy, 32'hA8);
        cmp32("post_rst_done", hd, 32'h400);
        idle(2);

        // Maximum N and G
        step(1'b1, 1'b0, 15, 15);
        idle(265);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            int n, g;
            bit s, a;
            s = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 99) == 0);
            n = $urandom_range(0, 15);
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            step(s, a, n, g);
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
